// File: rtl/loop_stack_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : loop_stack_ctrl
// Brief    : Loop-address stack controller with zero-latency TOS register and
//            one-cycle refill after a pop that exposes a lower entry.
// Revision : 1.0
// ============================================================================
module loop_stack_ctrl #(
    parameter int I_ADDR_WIDTH   = 16,
    parameter int MAX_LOOP_DEPTH = 32'h100,
    parameter int SP_WIDTH       = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [1:0]              cmd_op,
    input  logic [I_ADDR_WIDTH-1:0] cmd_addr,
    output logic [I_ADDR_WIDTH-1:0] top,
    output logic                    top_valid,
    output logic [SP_WIDTH:0]       depth,
    output logic                    overflow,
    output logic                    underflow,
    output logic [SP_WIDTH-1:0]     ram_write_addr,
    output logic                    ram_write_en,
    output logic [I_ADDR_WIDTH-1:0] ram_write_data,
    output logic [SP_WIDTH-1:0]     ram_read_addr,
    input  logic [I_ADDR_WIDTH-1:0] ram_read_data
);

    localparam logic [1:0]        c_op_push  = 2'b01;
    localparam logic [1:0]        c_op_pop   = 2'b10;
    localparam logic [1:0]        c_op_clear = 2'b11;
    localparam logic [SP_WIDTH:0] c_max_depth = (SP_WIDTH+1)'(MAX_LOOP_DEPTH);
    localparam logic [SP_WIDTH:0] c_one       = (SP_WIDTH+1)'(1);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_REFILL = 1'b1
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [I_ADDR_WIDTH-1:0]   r_top;
    logic                      r_top_valid;
    logic [SP_WIDTH:0]         r_depth;
    logic                      r_overflow;
    logic                      r_underflow;
    logic [SP_WIDTH-1:0]       r_rd_addr;

    logic                      w_accept;
    logic                      w_push_ok;
    logic                      w_pop_any;
    logic                      w_pop_deep;
    logic [SP_WIDTH-1:0]       w_rd_addr;

    assign w_accept   = cmd_valid & (r_state == ST_IDLE);
    assign w_push_ok  = w_accept & (cmd_op == c_op_push) & (r_depth < c_max_depth);
    assign w_pop_any  = w_accept & (cmd_op == c_op_pop) & (r_depth != '0);
    assign w_pop_deep = w_pop_any & (r_depth > c_one);
    // Low bits suffice: depth-2 stays below 2**SP_WIDTH even when depth is at full capacity.
    assign w_rd_addr  = r_depth[SP_WIDTH-1:0] - SP_WIDTH'(2);

    assign cmd_ready      = (r_state == ST_IDLE);
    assign top            = r_top;
    assign top_valid      = r_top_valid;
    assign depth          = r_depth;
    assign overflow       = r_overflow;
    assign underflow      = r_underflow;
    assign ram_write_en   = w_push_ok;
    assign ram_write_addr = r_depth[SP_WIDTH-1:0];
    assign ram_write_data = cmd_addr;
    assign ram_read_addr  = w_pop_deep ? w_rd_addr : r_rd_addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (w_pop_deep) w_state_nxt = ST_REFILL;
            ST_REFILL: w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_top       <= '0;
            r_top_valid <= 1'b0;
            r_depth     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            r_rd_addr   <= '0;
        end else if (r_state == ST_REFILL) begin
            r_top       <= ram_read_data;
            r_top_valid <= 1'b1;
        end else if (w_accept) begin
            case (cmd_op)
                c_op_push: begin
                    if (w_push_ok) begin
                        r_top       <= cmd_addr;
                        r_depth     <= r_depth + c_one;
                        r_top_valid <= 1'b1;
                    end else begin
                        r_overflow  <= 1'b1;
                    end
                end
                c_op_pop: begin
                    if (!w_pop_any) begin
                        r_underflow <= 1'b1;
                    end else begin
                        r_depth     <= r_depth - c_one;
                        r_top_valid <= 1'b0;
                        if (w_pop_deep) r_rd_addr <= w_rd_addr;
                    end
                end
                c_op_clear: begin
                    r_depth     <= '0;
                    r_top_valid <= 1'b0;
                    r_overflow  <= 1'b0;
                    r_underflow <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_loop_stack_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_loop_stack_ctrl
// Brief    : Scoreboard bench for loop_stack_ctrl with a registered-read RAM.
// Revision : 1.0
// ============================================================================
module tb_loop_stack_ctrl;

    localparam int AW  = 16;
    localparam int MAX = 4;
    localparam int SPW = 3;

    localparam logic [1:0] OP_NOP = 2'b00, OP_PUSH = 2'b01, OP_POP = 2'b10, OP_CLR = 2'b11;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           cmd_valid = 1'b0;
    logic           cmd_ready;
    logic [1:0]     cmd_op = '0;
    logic [AW-1:0]  cmd_addr = '0;
    logic [AW-1:0]  top;
    logic           top_valid;
    logic [SPW:0]   depth;
    logic           overflow, underflow;
    logic [SPW-1:0] ram_write_addr, ram_read_addr;
    logic           ram_write_en;
    logic [AW-1:0]  ram_write_data, ram_read_data;

    loop_stack_ctrl #(.I_ADDR_WIDTH(AW), .MAX_LOOP_DEPTH(MAX), .SP_WIDTH(SPW)) u_dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_addr(cmd_addr), .top(top), .top_valid(top_valid),
        .depth(depth), .overflow(overflow), .underflow(underflow),
        .ram_write_addr(ram_write_addr), .ram_write_en(ram_write_en),
        .ram_write_data(ram_write_data), .ram_read_addr(ram_read_addr),
        .ram_read_data(ram_read_data)
    );

    always #5 clk = ~clk;

    // Stack RAM with a registered read port
    logic [AW-1:0] mem [0:(1<<SPW)-1];
    always @(posedge clk) begin
        if (ram_write_en) mem[ram_write_addr] <= ram_write_data;
        ram_read_data <= mem[ram_read_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        int          cyc;
        logic [AW-1:0] top;
        logic        tv;
        int          dep;
        logic        ov;
        logic        un;
    } exp_t;

    typedef struct {
        int          addr;
        logic [AW-1:0] data;
    } wr_t;

    exp_t sq[$];
    wr_t  wq[$];

    // Reference model: the stack as a queue of addresses
    logic [AW-1:0] stk[$];
    logic [AW-1:0] m_top = '0;
    logic          m_ov = 1'b0, m_un = 1'b0;

    task automatic model_reset();
        stk.delete();
        m_top = '0;
        m_ov  = 1'b0;
        m_un  = 1'b0;
        sq.delete();
        wq.delete();
    endtask

    task automatic issue(input logic [1:0] op, input logic [AW-1:0] a);
        int w;
        exp_t e;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = a;
        w = 0;
        while (!cmd_ready && w < 10) begin
            @(negedge clk);
            w++;
        end
        if (!cmd_ready) begin
            chk("accept_timeout", 32'(cmd_ready), 32'd1);
            cmd_valid = 1'b0;
            return;
        end
        case (op)
            OP_PUSH: begin
                if (stk.size() < MAX) begin
                    wq.push_back('{addr: stk.size(), data: a});
                    stk.push_back(a);
                    m_top = a;
                end else begin
                    m_ov = 1'b1;
                end
            end
            OP_POP: begin
                if (stk.size() == 0) begin
                    m_un = 1'b1;
                end else begin
                    if (stk.size() >= 2) begin
                        #1;
                        chk("ram_read_addr", 32'(ram_read_addr), 32'(stk.size() - 2));
                    end
                    void'(stk.pop_back());
                    if (stk.size() > 0) m_top = stk[$];
                end
            end
            OP_CLR: begin
                stk.delete();
                m_ov = 1'b0;
                m_un = 1'b0;
            end
            default: ;
        endcase
        e.cyc = cyc;
        e.top = m_top;
        e.tv  = (stk.size() > 0);
        e.dep = stk.size();
        e.ov  = m_ov;
        e.un  = m_un;
        sq.push_back(e);
    endtask

    task automatic idle();
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op    = OP_NOP;
    endtask

    // Monitor: RAM writes and post-command status, sampled mid-cycle
    always @(negedge clk) begin
        exp_t e;
        wr_t  wr;
        #1;
        if (!rst) begin
            if (ram_write_en) begin
                if (wq.size() == 0) begin
                    chk("unexpected_write", 32'(ram_write_en), 32'd0);
                end else begin
                    wr = wq.pop_front();
                    chk("wr_addr", 32'(ram_write_addr), 32'(wr.addr));
                    chk("wr_data", 32'(ram_write_data), 32'(wr.data));
                end
            end
            if (sq.size() > 0 && sq[0].cyc < cyc) begin
                if (cmd_ready) begin
                    e = sq.pop_front();
                    chk("top",       32'(top),       32'(e.top));
                    chk("top_valid", 32'(top_valid), 32'(e.tv));
                    chk("depth",     32'(depth),     32'(e.dep));
                    chk("overflow",  32'(overflow),  32'(e.ov));
                    chk("underflow", 32'(underflow), 32'(e.un));
                end else if (cyc - sq[0].cyc > 4) begin
                    chk("status_timeout", 32'(cmd_ready), 32'd1);
                    void'(sq.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_depth",     32'(depth), 32'd0);
        chk("rst_top",       32'(top), 32'd0);
        chk("rst_top_valid", 32'(top_valid), 32'd0);
        chk("rst_flags",     32'({overflow, underflow}), 32'd0);
        chk("rst_wr_en",     32'(ram_write_en), 32'd0);
        chk("rst_addrs",     32'({ram_write_addr, ram_read_addr}), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Back-to-back pushes
        issue(OP_PUSH, 16'h0010);
        issue(OP_PUSH, 16'h0020);
        issue(OP_PUSH, 16'h0030);
        idle();

        // Pop with refill
        issue(OP_POP, 16'h0);
        idle();
        #1;
        chk("refill_ready", 32'(cmd_ready), 32'd0);
        chk("refill_tv",    32'(top_valid), 32'd0);
        idle();

        // Pop down to one, then to zero without a refill, then underflow
        issue(OP_POP, 16'h0);
        idle();
        issue(OP_POP, 16'h0);
        idle();
        #1;
        chk("no_refill_ready", 32'(cmd_ready), 32'd1);
        issue(OP_POP, 16'h0);
        idle();

        // Fill to capacity, overflow, clear
        for (int i = 1; i <= 5; i++) issue(OP_PUSH, 16'(16'h0100 * i));
        issue(OP_CLR, 16'h0);
        idle();

        // Reset during REFILL
        for (int i = 1; i <= 3; i++) issue(OP_PUSH, 16'(16'h0A00 + i));
        issue(OP_POP, 16'h0);
        @(negedge clk);
        rst = 1'b1;
        cmd_valid = 1'b0;
        model_reset();
        #1;
        chk("rst_refill_depth", 32'(depth), 32'd0);
        chk("rst_refill_tv",    32'(top_valid), 32'd0);
        chk("rst_refill_ready", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        #1 rst = 1'b0;
        issue(OP_PUSH, 16'h0BEE);
        idle();

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 99);
            if (r < 40)      issue(OP_PUSH, 16'($urandom));
            else if (r < 75) issue(OP_POP, 16'($urandom));
            else if (r < 80) issue(OP_CLR, 16'($urandom));
            else if (r < 90) issue(OP_NOP, 16'($urandom));
            else             idle();
        end
        idle();
        repeat (4) @(negedge clk);
        chk("status_drained", 32'(sq.size()), 32'd0);
        chk("writes_drained", 32'(wq.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
